// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - USB PID constants, CRC16 parameters and IN-packetizer state encoding
package usb_pkg;

  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_ACK   = 8'hD2;

  // CRC16-USB: poly 0x8005 processed LSB-first, hence the reflected constant.
  localparam logic [15:0] CRC16_INIT      = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PID,
    ST_FETCH,
    ST_LATCH,
    ST_SEND,
    ST_CRC_LO,
    ST_CRC_HI,
    ST_NAK,
    ST_PENDING,
    ST_REPLAY
  } pkt_state_e;

  // DATA PID selected by the current data toggle.
  function automatic logic [7:0] data_pid(input logic tog);
    return tog ? PID_DATA1 : PID_DATA0;
  endfunction

endpackage

// File: rtl/usb_in_packetizer_if.sv
// rtl/usb_in_packetizer_if.sv - token, queue and serializer signals of the IN packetizer
interface usb_in_packetizer_if;

  logic       in_req;
  logic       ack_in;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd_en;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic       toggle;
  logic       busy;

  // Packetizer side.
  modport master (
    input  in_req, ack_in, fifo_empty, fifo_data, tx_ready,
    output fifo_rd_en, tx_data, tx_valid, tx_last, toggle, busy
  );

  // Token decoder / queue / serializer side.
  modport slave (
    output in_req, ack_in, fifo_empty, fifo_data, tx_ready,
    input  fifo_rd_en, tx_data, tx_valid, tx_last, toggle, busy
  );

endinterface

// File: rtl/usb_crc16.sv
// rtl/usb_crc16.sv - combinational one-byte step of the reflected USB CRC16
module usb_crc16
  import usb_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  // Fold the byte into the low bits, then shift out eight bits LSB-first.
  always_comb begin
    logic [15:0] c;
    c = crc_in ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC16_POLY_REFL) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/usb_in_packetizer.sv
// rtl/usb_in_packetizer.sv - builds USB IN DATA/NAK packets from the byte queue with replay
module usb_in_packetizer
  import usb_pkg::*;
#(
  parameter int MAX_PKT   = 8,
  parameter bit EMPTY_ZLP = 1'b0
) (
  input  logic                r_clk,
  input  logic                rst,
  usb_in_packetizer_if.master bus
);

  localparam int CW = $clog2(MAX_PKT + 1);
  localparam int AW = (MAX_PKT > 1) ? $clog2(MAX_PKT) : 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PKT);

  pkt_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] rlen_q, rlen_d;
  logic [15:0]   crc_q, crc_d;
  logic [15:0]   crc_next;
  logic [7:0]    byte_q, byte_d;
  logic          toggle_q, toggle_d;
  logic          rvalid_q, rvalid_d;
  logic          replay_q, replay_d;
  logic          zlp_q, zlp_d;

  logic [7:0]    replay_mem [MAX_PKT];
  logic [AW-1:0] mem_idx;
  logic          mem_we;
  logic [7:0]    lat_byte;

  logic          rd_en;
  logic          tx_valid;
  logic          tx_last;
  logic [7:0]    tx_data;

  assign mem_idx  = cnt_q[AW-1:0];
  // A replay takes its payload from the stored copy instead of the queue.
  assign lat_byte = replay_q ? replay_mem[mem_idx] : bus.fifo_data;

  usb_crc16 u_crc (
    .crc_in  (crc_q),
    .data    (lat_byte),
    .crc_out (crc_next)
  );

  // State and packet context registers, cleared asynchronously.
  always_ff @(posedge r_clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rlen_q   <= '0;
      crc_q    <= CRC16_INIT;
      byte_q   <= 8'h00;
      toggle_q <= 1'b0;
      rvalid_q <= 1'b0;
      replay_q <= 1'b0;
      zlp_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rlen_q   <= rlen_d;
      crc_q    <= crc_d;
      byte_q   <= byte_d;
      toggle_q <= toggle_d;
      rvalid_q <= rvalid_d;
      replay_q <= replay_d;
      zlp_q    <= zlp_d;
    end
  end

  // Replay copy of the fresh payload, written as each queue byte is latched.
  always_ff @(posedge r_clk) begin
    if (mem_we) begin
      replay_mem[mem_idx] <= bus.fifo_data;
    end
  end

  // Next-state, queue pop and serializer outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rlen_d   = rlen_q;
    crc_d    = crc_q;
    byte_d   = byte_q;
    toggle_d = toggle_q;
    rvalid_d = rvalid_q;
    replay_d = replay_q;
    zlp_d    = zlp_q;
    mem_we   = 1'b0;
    rd_en    = 1'b0;
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    tx_data  = 8'h00;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_req) begin
          cnt_d    = '0;
          crc_d    = CRC16_INIT;
          replay_d = 1'b0;
          if (!bus.fifo_empty) begin
            zlp_d   = 1'b0;
            state_d = ST_PID;
          end else if (EMPTY_ZLP) begin
            zlp_d   = 1'b1;
            state_d = ST_PID;
          end else begin
            state_d = ST_NAK;
          end
        end
      end

      ST_PID, ST_REPLAY: begin
        tx_valid = 1'b1;
        tx_data  = data_pid(toggle_q);
        if (bus.tx_ready) begin
          state_d = zlp_q ? ST_CRC_LO : ST_FETCH;
        end
      end

      // Empty is looked at afresh on every visit so a short packet ends cleanly.
      ST_FETCH: begin
        if (replay_q) begin
          state_d = (cnt_q < rlen_q) ? ST_LATCH : ST_CRC_LO;
        end else if ((cnt_q < MAX_CNT) && !bus.fifo_empty) begin
          rd_en   = 1'b1;
          state_d = ST_LATCH;
        end else begin
          state_d = ST_CRC_LO;
        end
      end

      ST_LATCH: begin
        byte_d  = lat_byte;
        crc_d   = crc_next;
        mem_we  = !replay_q;
        cnt_d   = cnt_q + CW'(1);
        state_d = ST_SEND;
      end

      ST_SEND: begin
        tx_valid = 1'b1;
        tx_data  = byte_q;
        if (bus.tx_ready) begin
          state_d = ST_FETCH;
        end
      end

      ST_CRC_LO: begin
        tx_valid = 1'b1;
        tx_data  = ~crc_q[7:0];
        if (bus.tx_ready) begin
          state_d = ST_CRC_HI;
        end
      end

      ST_CRC_HI: begin
        tx_valid = 1'b1;
        tx_last  = 1'b1;
        tx_data  = ~crc_q[15:8];
        if (bus.tx_ready) begin
          rlen_d   = cnt_q;
          rvalid_d = 1'b1;
          state_d  = ST_PENDING;
        end
      end

      ST_NAK: begin
        tx_valid = 1'b1;
        tx_last  = 1'b1;
        tx_data  = PID_NAK;
        if (bus.tx_ready) begin
          state_d = ST_IDLE;
        end
      end

      // An ACK in the same cycle as a repeated IN wins; the IN is dropped.
      ST_PENDING: begin
        if (bus.ack_in) begin
          toggle_d = ~toggle_q;
          rvalid_d = 1'b0;
          state_d  = ST_IDLE;
        end else if (bus.in_req && rvalid_q) begin
          replay_d = 1'b1;
          cnt_d    = '0;
          crc_d    = CRC16_INIT;
          zlp_d    = (rlen_q == '0);
          state_d  = ST_REPLAY;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.tx_data    = tx_data;
  assign bus.tx_valid   = tx_valid;
  assign bus.tx_last    = tx_last;
  assign bus.toggle     = toggle_q;
  assign bus.busy       = (state_q != ST_IDLE) && (state_q != ST_PENDING);

endmodule
